// File: rtl/wasca_mem_pkg.sv
// Shared constants and sizing helpers for the dual-port on-chip memory.
// Imported by the RAM core and the Avalon-facing top level.
package wasca_mem_pkg;

   localparam int MEM_COLL_CNT_W = 8;

   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

   // Cycles from accept to readdatavalid: the RAM register plus an optional output stage.
   function automatic int read_latency(input int output_reg);
      return (output_reg != 0) ? 2 : 1;
   endfunction

endpackage

// File: rtl/wasca_ram_tdp_core.sv
// Byte-enabled true-dual-port RAM array: read-first on both ports, port A
// owns any byte lane it writes when both ports hit the same word.
module wasca_ram_tdp_core
   import wasca_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              a_we,
   input  logic                              a_re,
   input  logic [ADDR_WIDTH-1:0]             a_addr,
   input  logic [be_width(DATA_WIDTH)-1:0]   a_be,
   input  logic [DATA_WIDTH-1:0]             a_wdata,
   output logic [DATA_WIDTH-1:0]             a_rdata,
   input  logic                              b_we,
   input  logic                              b_re,
   input  logic [ADDR_WIDTH-1:0]             b_addr,
   input  logic [be_width(DATA_WIDTH)-1:0]   b_be,
   input  logic [DATA_WIDTH-1:0]             b_wdata,
   output logic [DATA_WIDTH-1:0]             b_rdata
);

   localparam int BEW = be_width(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   // Lane writes; port B drops a lane that port A also writes in the same word.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BEW; i++) begin
         if (a_we && a_be[i]) begin
            mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
         end
         if (b_we && b_be[i] && !(a_we && a_be[i] && (a_addr == b_addr))) begin
            mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
         end
      end
   end

   // Read registers load only on an accepted read, so they hold between reads.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         if (a_re) begin
            a_rdata <= mem[a_addr];
         end
         if (b_re) begin
            b_rdata <= mem[b_addr];
         end
      end
   end

endmodule

// File: rtl/wasca_onchip_memory_dp.sv
// Dual Avalon-MM slave on-chip RAM: accept logic, read-latency pipelines,
// waitrequest generation and a saturating write/write collision counter.
module wasca_onchip_memory_dp
   import wasca_mem_pkg::*;
#(
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 10,
   parameter int    OUTPUT_REG = 0,
   parameter string INIT_FILE  = "UNUSED"
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              clken,
   input  logic                              reset_req,
   input  logic                              s1_chipselect,
   input  logic                              s1_read,
   input  logic                              s1_write,
   input  logic [ADDR_WIDTH-1:0]             s1_address,
   input  logic [be_width(DATA_WIDTH)-1:0]   s1_byteenable,
   input  logic [DATA_WIDTH-1:0]             s1_writedata,
   output logic [DATA_WIDTH-1:0]             s1_readdata,
   output logic                              s1_readdatavalid,
   output logic                              s1_waitrequest,
   input  logic                              s2_chipselect,
   input  logic                              s2_read,
   input  logic                              s2_write,
   input  logic [ADDR_WIDTH-1:0]             s2_address,
   input  logic [be_width(DATA_WIDTH)-1:0]   s2_byteenable,
   input  logic [DATA_WIDTH-1:0]             s2_writedata,
   output logic [DATA_WIDTH-1:0]             s2_readdata,
   output logic                              s2_readdatavalid,
   output logic                              s2_waitrequest,
   input  logic                              coll_clear,
   output logic [MEM_COLL_CNT_W-1:0]         coll_count
);

   localparam int LAT = read_latency(OUTPUT_REG);

   if ((DATA_WIDTH % 8) != 0 || OUTPUT_REG < 0 || OUTPUT_REG > 1) begin : g_bad_params
      $error("wasca_onchip_memory_dp: DATA_WIDTH must be a multiple of 8 and OUTPUT_REG 0 or 1");
   end
   if (INIT_FILE != "UNUSED") begin : g_init_note
      $info("wasca_onchip_memory_dp: power-up contents come from %s via the vendor RAM flow", INIT_FILE);
   end

   logic                     active_s;
   logic [1:0]               acc_s;
   logic [1:0]               wr_s;
   logic [1:0]               rd_s;
   logic                     coll_s;
   logic [DATA_WIDTH-1:0]    core_q_s [2];
   logic [DATA_WIDTH-1:0]    rdata_s  [2];
   logic [1:0]               rvalid_s;
   logic [MEM_COLL_CNT_W-1:0] coll_cnt_r;

   assign active_s = clken & ~reset_req;

   // A write on the same port as a read suppresses the read.
   assign acc_s[0] = s1_chipselect & active_s & reset_n;
   assign acc_s[1] = s2_chipselect & active_s & reset_n;
   assign wr_s[0]  = acc_s[0] & s1_write;
   assign wr_s[1]  = acc_s[1] & s2_write;
   assign rd_s[0]  = acc_s[0] & s1_read & ~s1_write;
   assign rd_s[1]  = acc_s[1] & s2_read & ~s2_write;

   assign coll_s = wr_s[0] & wr_s[1] & (s1_address == s2_address)
                   & (|(s1_byteenable & s2_byteenable));

   wasca_ram_tdp_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_core (
      .clk     (clk),
      .reset_n (reset_n),
      .a_we    (wr_s[0]),
      .a_re    (rd_s[0]),
      .a_addr  (s1_address),
      .a_be    (s1_byteenable),
      .a_wdata (s1_writedata),
      .a_rdata (core_q_s[0]),
      .b_we    (wr_s[1]),
      .b_re    (rd_s[1]),
      .b_addr  (s2_address),
      .b_be    (s2_byteenable),
      .b_wdata (s2_writedata),
      .b_rdata (core_q_s[1])
   );

   for (genvar p = 0; p < 2; p++) begin : g_port
      if (LAT == 1) begin : g_lat1
         logic vld_r;

         // The core read register is the output; only the valid strobe is tracked here.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               vld_r <= 1'b0;
            end else if (active_s) begin
               vld_r <= rd_s[p];
            end
         end

         assign rdata_s[p]  = core_q_s[p];
         assign rvalid_s[p] = vld_r;
      end else begin : g_lat2
         logic [1:0]            vld_r;
         logic [DATA_WIDTH-1:0] out_r;

         // Extra output stage: capture the core word one cycle after it was read.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               vld_r <= 2'b00;
               out_r <= '0;
            end else if (active_s) begin
               vld_r <= {vld_r[0], rd_s[p]};
               if (vld_r[0]) begin
                  out_r <= core_q_s[p];
               end
            end
         end

         assign rdata_s[p]  = out_r;
         assign rvalid_s[p] = vld_r[1];
      end
   end

   // Saturating collision counter; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         coll_cnt_r <= '0;
      end else if (active_s) begin
         if (coll_clear) begin
            coll_cnt_r <= '0;
         end else if (coll_s && (coll_cnt_r != '1)) begin
            coll_cnt_r <= coll_cnt_r + MEM_COLL_CNT_W'(1);
         end
      end
   end

   assign s1_readdata      = rdata_s[0];
   assign s2_readdata      = rdata_s[1];
   assign s1_readdatavalid = rvalid_s[0];
   assign s2_readdatavalid = rvalid_s[1];
   assign s1_waitrequest   = ~active_s;
   assign s2_waitrequest   = ~active_s;
   assign coll_count       = coll_cnt_r;

endmodule

// File: tb/tb_wasca_onchip_memory_dp.sv
// Directed bench: two instances share every input; "a" has read latency 1
// (OUTPUT_REG=0) and "b" read latency 2 (OUTPUT_REG=1).
module tb_wasca_onchip_memory_dp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, clken, reset_req, coll_clear;
   logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
   logic [9:0]  s1_address, s2_address;
   logic [3:0]  s1_byteenable, s2_byteenable;
   logic [31:0] s1_writedata, s2_writedata;

   logic [31:0] a_s1_rdata, a_s2_rdata, b_s1_rdata, b_s2_rdata;
   logic        a_s1_rvalid, a_s2_rvalid, b_s1_rvalid, b_s2_rvalid;
   logic        a_s1_wait, a_s2_wait, b_s1_wait, b_s2_wait;
   logic [7:0]  a_coll, b_coll;

   int n_checks = 0;
   int n_fail   = 0;

   wasca_onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .OUTPUT_REG(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
      .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_readdata(a_s1_rdata), .s1_readdatavalid(a_s1_rvalid), .s1_waitrequest(a_s1_wait),
      .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
      .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
      .s2_readdata(a_s2_rdata), .s2_readdatavalid(a_s2_rvalid), .s2_waitrequest(a_s2_wait),
      .coll_clear(coll_clear), .coll_count(a_coll));

   wasca_onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .OUTPUT_REG(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
      .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_readdata(b_s1_rdata), .s1_readdatavalid(b_s1_rvalid), .s1_waitrequest(b_s1_wait),
      .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
      .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
      .s2_readdata(b_s2_rdata), .s2_readdatavalid(b_s2_rvalid), .s2_waitrequest(b_s2_wait),
      .coll_clear(coll_clear), .coll_count(b_coll));

   // One clock edge; outputs are looked at 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
      s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
      coll_clear = 1'b0;
   endtask

   task automatic s1_set(input logic rd, input logic wr, input logic [9:0] adr,
                         input logic [31:0] d, input logic [3:0] be);
      s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
      s1_address = adr; s1_writedata = d; s1_byteenable = be;
   endtask

   task automatic s2_set(input logic rd, input logic wr, input logic [9:0] adr,
                         input logic [31:0] d, input logic [3:0] be);
      s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
      s2_address = adr; s2_writedata = d; s2_byteenable = be;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
      s1_address = '0; s2_address = '0; s1_writedata = '0; s2_writedata = '0;
      s1_byteenable = '0; s2_byteenable = '0;
      idle();
      step(); step();
      n_checks++; if (a_s1_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_a_s1_rdata: got %h expected 00000000", a_s1_rdata); end
      n_checks++; if (b_s2_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_b_s2_rdata: got %h expected 00000000", b_s2_rdata); end
      n_checks++; if ({a_s1_rvalid, a_s2_rvalid, b_s1_rvalid, b_s2_rvalid} !== 4'b0000) begin n_fail++; $display("FAIL rst_valids: got %b expected 0000", {a_s1_rvalid, a_s2_rvalid, b_s1_rvalid, b_s2_rvalid}); end
      n_checks++; if (a_coll !== 8'd0) begin n_fail++; $display("FAIL rst_coll: got %0d expected 0", a_coll); end
      n_checks++; if ({a_s1_wait, a_s2_wait} !== 2'b00) begin n_fail++; $display("FAIL rst_wait: got %b expected 00", {a_s1_wait, a_s2_wait}); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_write_read();
      s1_set(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'b1111);
      step();
      idle();
      s2_set(1'b1, 1'b0, 10'h005, 32'h0, 4'b0000);
      step();
      n_checks++; if (a_s2_rvalid !== 1'b1 || a_s2_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_lat1: got v=%b d=%h expected v=1 d=deadbeef", a_s2_rvalid, a_s2_rdata); end
      n_checks++; if (b_s2_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_lat2_early: got %b expected 0", b_s2_rvalid); end
      idle();
      step();
      n_checks++; if (a_s2_rvalid !== 1'b0 || a_s2_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_lat1_hold: got v=%b d=%h expected v=0 d=deadbeef", a_s2_rvalid, a_s2_rdata); end
      n_checks++; if (b_s2_rvalid !== 1'b1 || b_s2_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_lat2: got v=%b d=%h expected v=1 d=deadbeef", b_s2_rvalid, b_s2_rdata); end
      step();
      n_checks++; if (b_s2_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_lat2_pulse: got %b expected 0", b_s2_rvalid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [4];
      vals[0] = 32'h0123_4567; vals[1] = 32'h89AB_CDEF; vals[2] = 32'hC0DE_0002; vals[3] = 32'hFACE_0003;
      for (int i = 0; i < 4; i++) begin
         s1_set(1'b0, 1'b1, 10'(i), vals[i], 4'b1111);
         step();
      end
      for (int c = 0; c < 6; c++) begin
         if (c < 4) s1_set(1'b1, 1'b0, 10'(c), 32'h0, 4'b0000);
         else idle();
         step();
         n_checks++; if (a_s1_rvalid !== (c < 4)) begin n_fail++; $display("FAIL b2b_a_valid[%0d]: got %b expected %b", c, a_s1_rvalid, (c < 4)); end
         if (c < 4) begin
            n_checks++; if (a_s1_rdata !== vals[c]) begin n_fail++; $display("FAIL b2b_a_data[%0d]: got %h expected %h", c, a_s1_rdata, vals[c]); end
         end
         n_checks++; if (b_s1_rvalid !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL b2b_b_valid[%0d]: got %b expected %b", c, b_s1_rvalid, (c >= 1 && c <= 4)); end
         if (c >= 1 && c <= 4) begin
            n_checks++; if (b_s1_rdata !== vals[c-1]) begin n_fail++; $display("FAIL b2b_b_data[%0d]: got %h expected %h", c, b_s1_rdata, vals[c-1]); end
         end
      end
   endtask

   task automatic test_collision();
      idle();
      s1_set(1'b0, 1'b1, 10'h010, 32'h11111111, 4'b0011);
      s2_set(1'b0, 1'b1, 10'h010, 32'h22222222, 4'b1110);
      step();
      n_checks++; if (a_coll !== 8'd1 || b_coll !== 8'd1) begin n_fail++; $display("FAIL coll_first: got %0d/%0d expected 1/1", a_coll, b_coll); end
      // Disjoint lanes on one word, then overlapping lanes on different words: neither counts.
      s1_set(1'b0, 1'b1, 10'h011, 32'h11111111, 4'b0011);
      s2_set(1'b0, 1'b1, 10'h011, 32'h22222222, 4'b1100);
      step();
      s1_set(1'b0, 1'b1, 10'h012, 32'h33333333, 4'b1111);
      s2_set(1'b0, 1'b1, 10'h013, 32'h44444444, 4'b1111);
      step();
      n_checks++; if (a_coll !== 8'd1) begin n_fail++; $display("FAIL coll_no_overlap: got %0d expected 1", a_coll); end
      idle();
      s1_set(1'b1, 1'b0, 10'h010, 32'h0, 4'b0000);
      step();
      n_checks++; if (a_s1_rdata !== 32'h22221111) begin n_fail++; $display("FAIL coll_lane_merge: got %h expected 22221111", a_s1_rdata); end
      s1_set(1'b1, 1'b0, 10'h011, 32'h0, 4'b0000);
      step();
      n_checks++; if (a_s1_rdata !== 32'h22221111) begin n_fail++; $display("FAIL disjoint_merge: got %h expected 22221111", a_s1_rdata); end
      s1_set(1'b0, 1'b1, 10'h010, 32'h11111111, 4'b0011);
      s2_set(1'b0, 1'b1, 10'h010, 32'h22222222, 4'b1110);
      for (int i = 0; i < 300; i++) step();
      n_checks++; if (a_coll !== 8'd255 || b_coll !== 8'd255) begin n_fail++; $display("FAIL coll_saturate: got %0d/%0d expected 255/255", a_coll, b_coll); end
      coll_clear = 1'b1;
      step();
      n_checks++; if (a_coll !== 8'd0) begin n_fail++; $display("FAIL coll_clear_prio: got %0d expected 0", a_coll); end
      idle();
      step();
   endtask

   task automatic test_read_first();
      s1_set(1'b0, 1'b1, 10'h020, 32'hAAAAAAAA, 4'b1111);
      step();
      s1_set(1'b0, 1'b1, 10'h020, 32'h55555555, 4'b1111);
      s2_set(1'b1, 1'b0, 10'h020, 32'h0, 4'b0000);
      step();
      n_checks++; if (a_s2_rvalid !== 1'b1 || a_s2_rdata !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL read_first_old: got v=%b d=%h expected v=1 d=aaaaaaaa", a_s2_rvalid, a_s2_rdata); end
      idle();
      s2_set(1'b1, 1'b0, 10'h020, 32'h0, 4'b0000);
      step();
      n_checks++; if (a_s2_rdata !== 32'h55555555) begin n_fail++; $display("FAIL read_first_new: got %h expected 55555555", a_s2_rdata); end
      s2_set(1'b1, 1'b1, 10'h030, 32'h12345678, 4'b1111);
      step();
      n_checks++; if (a_s2_rvalid !== 1'b0) begin n_fail++; $display("FAIL rw_same_port_novalid: got %b expected 0", a_s2_rvalid); end
      s2_set(1'b1, 1'b0, 10'h030, 32'h0, 4'b0000);
      step();
      n_checks++; if (a_s2_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rw_same_port_write: got %h expected 12345678", a_s2_rdata); end
      idle();
      step(); step();
   endtask

   task automatic test_freeze();
      reset_req = 1'b1;
      #1;
      n_checks++; if ({a_s1_wait, b_s2_wait} !== 2'b11) begin n_fail++; $display("FAIL reset_req_wait: got %b expected 11", {a_s1_wait, b_s2_wait}); end
      reset_req = 1'b0;
      s2_set(1'b1, 1'b0, 10'h005, 32'h0, 4'b0000);
      step();
      s2_set(1'b1, 1'b0, 10'h020, 32'h0, 4'b0000);
      clken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if ({a_s1_wait, b_s2_wait} !== 2'b11 || b_s2_rvalid !== 1'b0) begin n_fail++; $display("FAIL freeze[%0d]: got wait=%b v=%b expected wait=11 v=0", i, {a_s1_wait, b_s2_wait}, b_s2_rvalid); end
      end
      clken = 1'b1;
      idle();
      step();
      n_checks++; if (b_s2_rvalid !== 1'b1 || b_s2_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL freeze_resume: got v=%b d=%h expected v=1 d=deadbeef", b_s2_rvalid, b_s2_rdata); end
      step();
      n_checks++; if (b_s2_rvalid !== 1'b0 || a_s2_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL freeze_no_accept: got v=%b d=%h expected v=0 d=deadbeef", b_s2_rvalid, a_s2_rdata); end
   endtask

   task automatic test_reset_inflight();
      s1_set(1'b0, 1'b1, 10'h040, 32'h0, 4'b1111);
      s2_set(1'b0, 1'b1, 10'h040, 32'h0, 4'b1111);
      step();
      idle();
      s1_set(1'b1, 1'b0, 10'h005, 32'h0, 4'b0000);
      step();
      idle();
      reset_n = 1'b0;
      clken = 1'b0;
      step();
      n_checks++; if (b_s1_rvalid !== 1'b0 || b_s1_rdata !== 32'h0 || a_s1_rdata !== 32'h0) begin n_fail++; $display("FAIL inflight_reset: got v=%b b=%h a=%h expected v=0 b=0 a=0", b_s1_rvalid, b_s1_rdata, a_s1_rdata); end
      n_checks++; if (a_coll !== 8'd0) begin n_fail++; $display("FAIL inflight_reset_coll: got %0d expected 0", a_coll); end
      reset_n = 1'b1;
      clken = 1'b1;
      step();
      n_checks++; if (b_s1_rvalid !== 1'b0) begin n_fail++; $display("FAIL inflight_discard1: got %b expected 0", b_s1_rvalid); end
      step();
      n_checks++; if (b_s1_rvalid !== 1'b0) begin n_fail++; $display("FAIL inflight_discard2: got %b expected 0", b_s1_rvalid); end
      s1_set(1'b1, 1'b0, 10'h005, 32'h0, 4'b0000);
      step();
      idle();
      n_checks++; if (a_s1_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mem_intact_a: got %h expected deadbeef", a_s1_rdata); end
      step();
      n_checks++; if (b_s1_rvalid !== 1'b1 || b_s1_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mem_intact_b: got v=%b d=%h expected v=1 d=deadbeef", b_s1_rvalid, b_s1_rdata); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_collision();
      test_read_first();
      test_freeze();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
